// File: rtl/regfile_pkg.sv
// Shared defaults, FSM encoding and the address-validity helper for the register file.
package regfile_pkg;

   localparam int RF_DW     = 32;
   localparam int RF_DEPTH  = 32;
   localparam int RF_NUM_RD = 2;

   typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_t;

   // Entry 0 is the hardwired zero register; anything at or past depth does not exist.
   function automatic logic rf_addr_ok(input int unsigned addr, input int unsigned depth);
      return (addr != 0) && (addr < depth);
   endfunction

endpackage

// File: rtl/regfile_rd_mux.sv
// One combinational read port: range/zero gating, gating while the clear sweep runs,
// and an optional same-cycle write bypass selected by BYPASS.
module regfile_rd_mux
   import regfile_pkg::*;
#(
   parameter int DW     = RF_DW,
   parameter int DEPTH  = RF_DEPTH,
   parameter int AW     = $clog2(RF_DEPTH),
   parameter bit BYPASS = 1'b0
) (
   input  logic [DEPTH-1:0][DW-1:0] rf,
   input  logic                     busy,
   input  logic [AW-1:0]            addr,
   input  logic                     wen,
   input  logic [AW-1:0]            waddr,
   input  logic [DW-1:0]            wdata,
   output logic [DW-1:0]            data
);

   always_comb begin
      data = '0;
      if (!busy && rf_addr_ok(32'(addr), DEPTH)) begin
         data = rf[addr];
         // addr already passed the range check, so a matching waddr is valid too
         if (BYPASS && wen && (waddr == addr)) data = wdata;
      end
   end

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file: storage, post-reset clear sweep and write decode.
// Define REGFILE_BYPASS_EN to let the read ports see a same-cycle write.
module regfile_param
   import regfile_pkg::*;
#(
   parameter  int DW     = RF_DW,
   parameter  int DEPTH  = RF_DEPTH,
   parameter  int NUM_RD = RF_NUM_RD,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 reset,
   output logic                 busy,
   input  logic                 wen,
   input  logic [AW-1:0]        waddr,
   input  logic [DW-1:0]        wdata,
   input  logic [NUM_RD*AW-1:0] raddr,
   output logic [NUM_RD*DW-1:0] rdata,
   input  logic [AW-1:0]        test_addr,
   output logic [DW-1:0]        test_data
);

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP_EN = 1'b1;
`else
   localparam bit BYP_EN = 1'b0;
`endif

   rf_state_t               state_q, state_d;
   logic [AW-1:0]           clr_ptr_q, clr_ptr_d;
   logic                    busy_q, busy_d;
   logic [DEPTH-1:0][DW-1:0] rf_q, rf_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= RF_CLEAR;
         clr_ptr_q <= AW'(1);
         busy_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
         busy_q    <= busy_d;
      end
      rf_q <= rf_d;
   end

   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      busy_d    = busy_q;
      rf_d      = rf_q;
      unique case (state_q)
         RF_CLEAR: begin
            rf_d[clr_ptr_q] = '0;
            clr_ptr_d       = clr_ptr_q + AW'(1);
            if (clr_ptr_q == AW'(DEPTH-1)) begin
               state_d = RF_IDLE;
               busy_d  = 1'b0;
            end
         end
         default: begin
            if (wen && rf_addr_ok(32'(waddr), DEPTH)) rf_d[waddr] = wdata;
         end
      endcase
      // Entry 0 is never written; pin it so nothing downstream ever sees X there.
      rf_d[0] = '0;
   end

   assign busy = busy_q;

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      regfile_rd_mux #(
         .DW(DW), .DEPTH(DEPTH), .AW(AW), .BYPASS(BYP_EN)
      ) u_rd (
         .rf    (rf_q),
         .busy  (busy_q),
         .addr  (raddr[i*AW +: AW]),
         .wen   (wen),
         .waddr (waddr),
         .wdata (wdata),
         .data  (rdata[i*DW +: DW])
      );
   end

   regfile_rd_mux #(
      .DW(DW), .DEPTH(DEPTH), .AW(AW), .BYPASS(1'b0)
   ) u_test (
      .rf    (rf_q),
      .busy  (busy_q),
      .addr  (test_addr),
      .wen   (1'b0),
      .waddr (waddr),
      .wdata (wdata),
      .data  (test_data)
   );

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench for regfile_param: a 32-deep 2-port instance and a 24-deep 3-port instance.
module tb_regfile_param;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   // instance A: DEPTH 32, NUM_RD 2
   logic        busy_a, wen_a;
   logic [4:0]  waddr_a, test_addr_a;
   logic [31:0] wdata_a, test_data_a;
   logic [9:0]  raddr_a;
   logic [63:0] rdata_a;
   // instance B: DEPTH 24, NUM_RD 3
   logic        busy_b, wen_b;
   logic [4:0]  waddr_b, test_addr_b;
   logic [31:0] wdata_b, test_data_b;
   logic [14:0] raddr_b;
   logic [95:0] rdata_b;

   regfile_param #(.DW(32), .DEPTH(32), .NUM_RD(2)) u_dut_a (
      .clk(clk), .reset(reset), .busy(busy_a), .wen(wen_a), .waddr(waddr_a),
      .wdata(wdata_a), .raddr(raddr_a), .rdata(rdata_a),
      .test_addr(test_addr_a), .test_data(test_data_a));

   regfile_param #(.DW(32), .DEPTH(24), .NUM_RD(3)) u_dut_b (
      .clk(clk), .reset(reset), .busy(busy_b), .wen(wen_b), .waddr(waddr_b),
      .wdata(wdata_b), .raddr(raddr_b), .rdata(rdata_b),
      .test_addr(test_addr_b), .test_data(test_data_b));

   int n_chk = 0;
   int n_fail = 0;
   logic [31:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [31:0] v);
      exp_q.push_back(v);
   endtask

   task automatic pop_chk(input string tag, input logic [31:0] got);
      if (exp_q.size() == 0) chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      else chk(tag, got, exp_q.pop_front());
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Counts busy cycles of both instances from reset release; optionally attempts
   // a write to A's entry 3 while the sweep is already past it.
   task automatic sweep(input int wr_at, output int ca, output int cb);
      ca = 0;
      cb = 0;
      test_addr_a = 5'd20;
      raddr_a     = {5'd0, 5'd20};
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (i == 0) begin
            push(32'd0); pop_chk("busy_gate_test", test_data_a);
            push(32'd0); pop_chk("busy_gate_rd0", rdata_a[31:0]);
         end
         if (busy_a === 1'b1) ca++;
         if (busy_b === 1'b1) cb++;
         if (busy_a !== 1'b1 && busy_b !== 1'b1) break;
         step();
         if (i == wr_at) begin
            wen_a = 1'b1; waddr_a = 5'd3; wdata_a = 32'hCAFE_0003;
         end else begin
            wen_a = 1'b0;
         end
      end
      wen_a = 1'b0;
   endtask

   initial begin
      int ca, cb;
      wen_a = 0; waddr_a = 0; wdata_a = 0; raddr_a = 0; test_addr_a = 0;
      wen_b = 0; waddr_b = 0; wdata_b = 0; raddr_b = 0; test_addr_b = 0;

      // reset held three cycles
      step();
      @(negedge clk);
      chk("reset_busy_a", 32'(busy_a), 32'd1);
      chk("reset_busy_b", 32'(busy_b), 32'd1);
      step();
      step();
      reset = 1'b0;

      sweep(-1, ca, cb);
      chk("sweep_len_a", 32'(ca), 32'd31);
      chk("sweep_len_b", 32'(cb), 32'd23);

      // every entry reads zero via the test port
      for (int a = 0; a < 32; a++) begin
         step();
         test_addr_a = 5'(a);
         push(32'd0);
         @(negedge clk);
         pop_chk($sformatf("clr_test_%0d", a), test_data_a);
      end

      // basic write / read
      step();
      wen_a = 1; waddr_a = 5'd5; wdata_a = 32'hDEAD_BEEF;
      step();
      wen_a = 0; raddr_a = {5'd5, 5'd5}; test_addr_a = 5'd5;
      push(32'hDEAD_BEEF); push(32'hDEAD_BEEF); push(32'hDEAD_BEEF);
      @(negedge clk);
      pop_chk("wr5_rd0", rdata_a[31:0]);
      pop_chk("wr5_rd1", rdata_a[63:32]);
      pop_chk("wr5_test", test_data_a);

      // zero register ignores writes, also in the write cycle itself
      step();
      wen_a = 1; waddr_a = 5'd0; wdata_a = 32'hFFFF_FFFF; raddr_a = {5'd0, 5'd0};
      for (int c = 0; c < 3; c++) begin
         push(32'd0); push(32'd0);
         @(negedge clk);
         pop_chk($sformatf("zero_rd0_c%0d", c), rdata_a[31:0]);
         pop_chk($sformatf("zero_rd1_c%0d", c), rdata_a[63:32]);
         step();
         wen_a = 0;
      end

      // same-cycle write and read of entry 7
      wen_a = 1; waddr_a = 5'd7; wdata_a = 32'h1234_5678; raddr_a = {5'd5, 5'd7};
      test_addr_a = 5'd7;
      push(BYP ? 32'h1234_5678 : 32'd0); push(32'd0); push(32'hDEAD_BEEF);
      @(negedge clk);
      pop_chk("samecyc_rd0", rdata_a[31:0]);
      pop_chk("samecyc_test", test_data_a);
      pop_chk("samecyc_rd1_other", rdata_a[63:32]);
      step();
      wen_a = 0;
      push(32'h1234_5678); push(32'h1234_5678);
      @(negedge clk);
      pop_chk("after_rd0", rdata_a[31:0]);
      pop_chk("after_test", test_data_a);

      // 24-deep instance: out-of-range write dropped, top entry on all ports
      step();
      wen_b = 1; waddr_b = 5'd30; wdata_b = 32'h1111_1111;
      step();
      waddr_b = 5'd23; wdata_b = 32'h0BAD_F00D;
      step();
      wen_b = 0; raddr_b = {5'd23, 5'd23, 5'd23}; test_addr_b = 5'd30;
      push(32'h0BAD_F00D); push(32'h0BAD_F00D); push(32'h0BAD_F00D); push(32'd0);
      @(negedge clk);
      pop_chk("b_rd0_23", rdata_b[31:0]);
      pop_chk("b_rd1_23", rdata_b[63:32]);
      pop_chk("b_rd2_23", rdata_b[95:64]);
      pop_chk("b_test_30", test_data_b);
      step();
      raddr_b = {5'd23, 5'd30, 5'd22};
      push(32'd0); push(32'd0); push(32'h0BAD_F00D);
      @(negedge clk);
      pop_chk("b_rd0_22", rdata_b[31:0]);
      pop_chk("b_rd1_30", rdata_b[63:32]);
      pop_chk("b_rd2_23b", rdata_b[95:64]);

      // reset, then a one-cycle reset pulse ten cycles into the sweep
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      repeat (10) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      sweep(20, ca, cb);
      chk("resweep_len_a", 32'(ca), 32'd31);
      chk("resweep_len_b", 32'(cb), 32'd23);

      step();
      raddr_a = {5'd5, 5'd3}; test_addr_a = 5'd7; raddr_b = {5'd0, 5'd0, 5'd23};
      push(32'd0); push(32'd0); push(32'd0); push(32'd0);
      @(negedge clk);
      pop_chk("busy_wr_dropped", rdata_a[31:0]);
      pop_chk("recleared_5", rdata_a[63:32]);
      pop_chk("recleared_7", test_data_a);
      pop_chk("b_recleared_23", rdata_b[31:0]);

      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
